// File: rtl/line_timing_gen.sv
// Pixel/line timing generator feeding a 5-bit line counter.
// Each line runs through active pixels, horizontal blanking and one LINE_END
// cycle in which the counter's endFrame decides between another line and
// vertical blanking. All outputs decode registered state only.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | stopped, line counter held clear
//   ACTIVE   | active pixels, pixX = hcount
//   HBLANK   | horizontal blanking, newLine on the last cycle
//   LINE_END | single cycle, endFrame sampled here
//   VBLANK   | vertical blanking, line counter held clear
module line_timing_gen #(
    parameter int H_ACTIVE = 32,
    parameter int H_BLANK  = 8,
    parameter int V_BLANK  = 16,
    parameter int PIX_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             endFrame,
    output logic             newLine,
    output logic             lineCntEnb,
    output logic             pixValid,
    output logic [PIX_W-1:0] pixX,
    output logic             frameStart,
    output logic [7:0]       frameCnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACTIVE   = 3'd1,
        S_HBLANK   = 3'd2,
        S_LINE_END = 3'd3,
        S_VBLANK   = 3'd4
    } state_t;

    localparam logic [PIX_W-1:0] HA_LAST = PIX_W'(H_ACTIVE - 1);
    localparam logic [PIX_W-1:0] HB_LAST = PIX_W'(H_BLANK - 1);
    localparam logic [PIX_W-1:0] VB_LAST = PIX_W'(V_BLANK - 1);
    localparam logic [PIX_W-1:0] ONE     = PIX_W'(1);

    state_t           state, next_state;
    logic [PIX_W-1:0] hcount, next_hcount;
    logic [7:0]       frame_cnt, next_frame_cnt;
    logic             first_line, next_first_line;

    // State, position, frame count and first-line flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hcount     <= '0;
            frame_cnt  <= '0;
            first_line <= 1'b0;
        end else begin
            state      <= next_state;
            hcount     <= next_hcount;
            frame_cnt  <= next_frame_cnt;
            first_line <= next_first_line;
        end
    end

    // Next-state and counter update; a dropped enb aborts any line-phase state.
    always_comb begin
        next_state      = state;
        next_hcount     = hcount;
        next_frame_cnt  = frame_cnt;
        next_first_line = first_line;
        case (state)
            S_IDLE: begin
                next_hcount = '0;
                if (enb) begin
                    next_state      = S_ACTIVE;
                    next_first_line = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!enb) begin
                    next_state      = S_IDLE;
                    next_hcount     = '0;
                    next_first_line = 1'b0;
                end else if (hcount == HA_LAST) begin
                    next_state      = S_HBLANK;
                    next_hcount     = '0;
                    next_first_line = 1'b0;
                end else begin
                    next_hcount = hcount + ONE;
                end
            end
            S_HBLANK: begin
                if (!enb) begin
                    next_state  = S_IDLE;
                    next_hcount = '0;
                end else if (hcount == HB_LAST) begin
                    next_state  = S_LINE_END;
                    next_hcount = '0;
                end else begin
                    next_hcount = hcount + ONE;
                end
            end
            S_LINE_END: begin
                next_hcount = '0;
                if (!enb) begin
                    next_state = S_IDLE;
                end else if (endFrame) begin
                    next_state     = S_VBLANK;
                    next_frame_cnt = frame_cnt + 8'd1;
                end else begin
                    next_state = S_ACTIVE;
                end
            end
            S_VBLANK: begin
                if (hcount == VB_LAST) begin
                    next_hcount = '0;
                    if (enb) begin
                        next_state      = S_ACTIVE;
                        next_first_line = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end else begin
                    next_hcount = hcount + ONE;
                end
            end
            default: begin
                next_state      = S_IDLE;
                next_hcount     = '0;
                next_first_line = 1'b0;
            end
        endcase
    end

    // Moore output decode of the registered state and hcount.
    always_comb begin
        newLine    = 1'b0;
        lineCntEnb = 1'b0;
        pixValid   = 1'b0;
        pixX       = '0;
        frameStart = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_ACTIVE: begin
                pixValid   = 1'b1;
                pixX       = hcount;
                lineCntEnb = 1'b1;
                frameStart = first_line && (hcount == '0);
            end
            S_HBLANK: begin
                lineCntEnb = 1'b1;
                newLine    = (hcount == HB_LAST);
            end
            S_LINE_END: begin
                lineCntEnb = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign frameCnt = frame_cnt;

endmodule

// File: tb/tb_line_timing_gen.sv
// Bench for line_timing_gen: default-size instance plus a tiny instance for
// the 256-frame wrap, each with a 5-bit line counter and a position-based model.
module tb_line_timing_gen;

    logic clk, rst, rst2, enb, enb2;

    logic       nl0, lce0, pv0, fs0, busy0, ef0;
    logic [5:0] px0;
    logic [7:0] fc0;
    logic [4:0] lc0;

    logic       nl1, lce1, pv1, fs1, busy1, ef1;
    logic [5:0] px1;
    logic [7:0] fc1;
    logic [4:0] lc1;

    int checks = 0;
    int errors = 0;

    int m_run[2];
    int m_t[2];
    int m_fc[2];

    line_timing_gen #(.H_ACTIVE(32), .H_BLANK(8), .V_BLANK(16), .PIX_W(6)) dut0 (
        .clk(clk), .rst(rst), .enb(enb), .endFrame(ef0), .newLine(nl0),
        .lineCntEnb(lce0), .pixValid(pv0), .pixX(px0), .frameStart(fs0),
        .frameCnt(fc0), .busy(busy0)
    );

    line_timing_gen #(.H_ACTIVE(2), .H_BLANK(1), .V_BLANK(2), .PIX_W(6)) dut1 (
        .clk(clk), .rst(rst2), .enb(enb2), .endFrame(ef1), .newLine(nl1),
        .lineCntEnb(lce1), .pixValid(pv1), .pixX(px1), .frameStart(fs1),
        .frameCnt(fc1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #8 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)        lc0 <= 5'd0;
        else if (!lce0) lc0 <= 5'd0;
        else if (nl0)   lc0 <= lc0 + 5'd1;
    end
    assign ef0 = (lc0 == 5'd24);

    always @(posedge clk or posedge rst2) begin
        if (rst2)       lc1 <= 5'd0;
        else if (!lce1) lc1 <= 5'd0;
        else if (nl1)   lc1 <= lc1 + 5'd1;
    end
    assign ef1 = (lc1 == 5'd24);

    function automatic int ha(input int i); return (i == 0) ? 32 : 2; endfunction
    function automatic int hb(input int i); return (i == 0) ? 8 : 1; endfunction
    function automatic int vb(input int i); return (i == 0) ? 16 : 2; endfunction

    // Model: a frame is 24 lines of (ha+hb+1) cycles followed by vb blanking cycles.
    task automatic model_step(input int i, input logic e);
        int act, frm;
        act = 24 * (ha(i) + hb(i) + 1);
        frm = act + vb(i);
        if (m_run[i] == 0) begin
            if (e) begin m_run[i] = 1; m_t[i] = 0; end
        end else if (m_t[i] < act) begin
            if (!e) m_run[i] = 0;
            else begin
                if (m_t[i] == act - 1) m_fc[i] = (m_fc[i] + 1) % 256;
                m_t[i] = m_t[i] + 1;
            end
        end else if (m_t[i] == frm - 1) begin
            if (e) m_t[i] = 0; else m_run[i] = 0;
        end else begin
            m_t[i] = m_t[i] + 1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin m_run[0] = 0; m_t[0] = 0; m_fc[0] = 0; end
        else model_step(0, enb);
        if (rst2) begin m_run[1] = 0; m_t[1] = 0; m_fc[1] = 0; end
        else model_step(1, enb2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int i);
        int L, act, p, t;
        logic [31:0] e_pv, e_px, e_nl, e_lce, e_fs, e_busy, e_lc;
        L = ha(i) + hb(i) + 1;
        act = 24 * L;
        t = m_t[i];
        p = t % L;
        {e_pv, e_px, e_nl, e_lce, e_fs, e_busy, e_lc} = '0;
        if (m_run[i] != 0) begin
            e_busy = 1;
            if (t < act) begin
                e_pv  = (p < ha(i)) ? 1 : 0;
                e_px  = (p < ha(i)) ? p : 0;
                e_nl  = (p == ha(i) + hb(i) - 1) ? 1 : 0;
                e_lce = 1;
                e_fs  = (t == 0) ? 1 : 0;
                e_lc  = t / L + ((p == L - 1) ? 1 : 0);
            end else begin
                e_lc = (t == act) ? 24 : 0;
            end
        end
        if (i == 0) begin
            check("pixValid",   32'(pv0),   e_pv);
            check("pixX",       32'(px0),   e_px);
            check("newLine",    32'(nl0),   e_nl);
            check("lineCntEnb", 32'(lce0),  e_lce);
            check("frameStart", 32'(fs0),   e_fs);
            check("busy",       32'(busy0), e_busy);
            check("frameCnt",   32'(fc0),   32'(m_fc[0]));
            if (m_run[0] != 0) check("lineCount", 32'(lc0), e_lc);
        end else begin
            check("w_pixValid",   32'(pv1),   e_pv);
            check("w_pixX",       32'(px1),   e_px);
            check("w_newLine",    32'(nl1),   e_nl);
            check("w_lineCntEnb", 32'(lce1),  e_lce);
            check("w_frameStart", 32'(fs1),   e_fs);
            check("w_busy",       32'(busy1), e_busy);
            check("w_frameCnt",   32'(fc1),   32'(m_fc[1]));
            if (m_run[1] != 0) check("w_lineCount", 32'(lc1), e_lc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic wait_t(input int target);
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (m_run[0] != 0 && m_t[0] == target) return;
        end
        checks++;
        errors++;
        $error("FAIL wait_position observed=timeout expected=%0d", target);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; enb = 1'b0; enb2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Three full frames with enb held high.
        enb = 1'b1;
        repeat (3000) tick();
        check("three_frames_cnt", 32'(fc0), 32'd3);

        // Abort at pixX=10 of line 5.
        wait_t(4 * 41 + 10);
        enb = 1'b0;
        tick();
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_lce",  32'(lce0),  32'd0);
        repeat ($urandom_range(1, 5)) tick();
        enb = 1'b1;
        tick();
        check("restart_fs",  32'(fs0), 32'd1);
        check("restart_px",  32'(px0), 32'd0);
        check("restart_lc",  32'(lc0), 32'd0);

        // Drop enb part way through vertical blanking.
        wait_t(984 + $urandom_range(0, 14));
        enb = 1'b0;
        repeat (20) tick();
        check("vblank_drop_busy", 32'(busy0), 32'd0);
        enb = 1'b1;

        // Random enb toggling.
        repeat (3000) begin
            if ($urandom_range(0, 149) == 0) enb = ~enb;
            tick();
        end
        enb = 1'b1;

        // Asynchronous reset mid-ACTIVE, off the clock edges.
        wait_t(5 * 41 + $urandom_range(0, 31));
        #3 rst = 1'b1;
        #1;
        check("async_pixValid", 32'(pv0),   32'd0);
        check("async_lce",      32'(lce0),  32'd0);
        check("async_busy",     32'(busy0), 32'd0);
        check("async_frameCnt", 32'(fc0),   32'd0);
        tick();
        rst = 1'b0;
        repeat (1100) tick();

        // 256-frame wrap on the small instance (98 cycles per frame).
        enb = 1'b0;
        rst2 = 1'b0;
        tick();
        enb2 = 1'b1;
        repeat (97 + 98 * 255 - 1) tick();
        check("wrap_255", 32'(fc1), 32'd255);
        tick();
        check("wrap_0", 32'(fc1), 32'd0);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_timing_gen.md
Name: line_timing_gen

Overview:
- Pixel/line timing generator that sits directly upstream of the 5-bit line counter.
- Walks each line through active pixels and horizontal blanking, and emits the one-cycle newLine pulse plus the line-counter enable.
- Samples the counter's endFrame to enter vertical blanking, then restarts the next frame.
- Downstream pattern logic uses its pixValid/pixX/frameStart outputs.

Parameters:
- H_ACTIVE, 32, active pixels per line (≥2)
- H_BLANK, 8, horizontal blanking cycles per line (≥1)
- V_BLANK, 16, vertical blanking cycles per frame (≥2)
- PIX_W, 6, width of pixX and hcount; must hold max(H_ACTIVE, H_BLANK, V_BLANK)-1

Ports:
- clk, input, 1, 16 ns master clock
- rst, input, 1, asynchronous active-high reset
- enb, input, 1, active-high run enable
- endFrame, input, 1, from line counter; combinational, high when 24 lines counted
- newLine, output, 1, one-cycle pulse on the last HBLANK cycle of every line
- lineCntEnb, output, 1, enable to the line counter; low clears it
- pixValid, output, 1, high during active pixels
- pixX, output, PIX_W, active pixel index 0..H_ACTIVE-1; 0 when pixValid=0
- frameStart, output, 1, one-cycle pulse on the first ACTIVE cycle of a frame
- frameCnt, output, 8, completed-frame count; wraps 255→0
- busy, output, 1, high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- On rst: state=IDLE, hcount=0, frameCnt=0, first-line flag=0. All outputs 0 while rst is high and on the first edge after release.
- Outputs are Moore decodes of registered state/hcount; there are no combinational paths from inputs to outputs.
- States: IDLE, ACTIVE, HBLANK, LINE_END, VBLANK.
- IDLE:
  - hcount=0; lineCntEnb=0.
  - enb=1 → ACTIVE, hcount=0, first-line flag set.
- ACTIVE:
  - pixValid=1, pixX=hcount, lineCntEnb=1.
  - frameStart=1 only when hcount=0 and first-line flag is set; the flag clears on leaving ACTIVE.
  - hcount=H_ACTIVE-1 → HBLANK, hcount=0. Otherwise hcount+1.
- HBLANK:
  - lineCntEnb=1; newLine=1 only when hcount=H_BLANK-1.
  - At hcount=H_BLANK-1 → LINE_END. Otherwise hcount+1.
- LINE_END (exactly one cycle):
  - lineCntEnb=1; the counter has already registered the increment, so endFrame is valid here.
  - endFrame=1 → VBLANK, hcount=0, frameCnt+1 (8-bit wrap).
  - endFrame=0 → ACTIVE, hcount=0.
- VBLANK:
  - lineCntEnb=0, which clears the counter, so endFrame drops the next cycle.
  - Stays V_BLANK cycles (hcount 0..V_BLANK-1).
  - On the last cycle: enb=1 → ACTIVE with first-line flag set; enb=0 → IDLE.
- Timing:
  - Line period = H_ACTIVE+H_BLANK+1 cycles (41 at defaults).
  - Frame period = 24×41+V_BLANK = 1000 cycles at defaults.
- enb deasserted in ACTIVE/HBLANK/LINE_END → abort to IDLE next edge. hcount=0, frameCnt unchanged, and lineCntEnb=0 clears the counter.
- enb deasserted in VBLANK: blanking completes, then IDLE.
- endFrame high outside LINE_END is ignored.
- Asynchronous rst mid-frame: immediate return to reset values; the frameCnt value is lost.
- hcount never exceeds its terminal value in any state; there are no illegal-state lockups (default → IDLE).

Test Plan:
- Reset then enb=1 held, with a real Counter5Bit attached:
  - frameStart pulses 1000 cycles apart.
  - 24 newLine pulses per frame, 41 cycles apart.
  - frameCnt = 1, 2, 3 after each VBLANK entry.
- Single line check, one frame:
  - pixValid high for exactly 32 consecutive cycles; pixX steps 0..31.
  - newLine arrives 8 cycles after pixX=31, then 1 LINE_END cycle.
  - Next pixX=0 lands 41 cycles after the previous pixX=0.
- Vertical blanking:
  - endFrame goes high in LINE_END of line 24 → VBLANK.
  - lineCntEnb=0 for 16 cycles; endFrame returns to 0 within 1 cycle.
  - No newLine or pixValid during VBLANK.
- Mid-line abort:
  - Drop enb at pixX=10 of line 5 → IDLE next cycle; lineCntEnb=0; busy=0; frameCnt unchanged.
  - Re-raise enb → frameStart with pixX=0, and the counter restarts from 0.
- enb drop during VBLANK:
  - The full 16 blanking cycles complete, then IDLE; no frameStart.
- Asynchronous reset pulse mid-ACTIVE, not aligned to clk:
  - All outputs 0 immediately, and frameCnt=0.
- Wrap test:
  - Run 256 frames → frameCnt returns to 0.
